// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the irq_ctrl interrupt controller: register map,
// bus FSM encoding, MASK reset value and the priority-encoder helper.
package irq_ctrl_pkg;

  localparam logic [4:0] ADR_STATUS = 5'h00;
  localparam logic [4:0] ADR_MASK   = 5'h04;
  localparam logic [4:0] ADR_CLEAR  = 5'h08;
  localparam logic [4:0] ADR_RAW    = 5'h0C;
  localparam logic [4:0] ADR_ID     = 5'h10;

  // Every source starts masked so nothing reaches the CPU until software opts in.
  localparam logic [31:0] MASK_RST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_ACK
  } bus_state_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [4:0] lowest_set(input logic [31:0] v);
    lowest_set = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) lowest_set = 5'(i);
    end
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchroniser for one asynchronous interrupt line.
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // NOTE: flops use non-blocking assignments so every stage samples the
  // previous stage's old value, giving a true STAGES-deep shift.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_chain <= '0;
    else          r_chain <= {r_chain[STAGES-2:0], i_d};
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// Wishbone-slave interrupt controller: synchronise, latch, mask, drive one CPU IRQ.
// Optional ID register at 0x10 is built when IRQ_CTRL_PRIO_ID_EN is defined.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [31:0]        i_wb_dat,
  input  logic [4:0]         i_wb_adr,
  input  logic               i_wb_stb,
  input  logic               i_wb_cyc,
  input  logic               i_wb_wen,
  input  logic [3:0]         i_wb_sel,
  output logic [31:0]        o_wb_dat,
  output logic               o_wb_ack,
  input  logic [NUM_IRQ-1:0] i_irq,
  output logic               o_irq
);

  bus_state_t         r_state;
  bus_state_t         w_state_next;
  logic               r_ack;
  logic [31:0]        r_rdat;
  logic               r_irq;
  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] r_mask;
  logic [NUM_IRQ-1:0] w_sync;
  logic [NUM_IRQ-1:0] w_active;
  logic [NUM_IRQ-1:0] w_lane_en;
  logic [NUM_IRQ-1:0] w_clr;
  logic               w_wr_mask;
  logic               w_wr_clear;
  logic [31:0]        w_rd_data;
  logic               w_unused;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_sync #(
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_irq[g]),
      .o_q     (w_sync[g])
    );
  end

  // Bus FSM: one cycle to act on the request, one to raise ack.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // NOTE: assign a default first so no path through the case leaves the
  // output unassigned, which would infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        // A still-high ack means the current stb belongs to the finished transfer.
        if (i_wb_stb && i_wb_cyc && !r_ack) begin
          w_state_next = i_wb_wen ? ST_WRITE : ST_READ;
        end
      end
      ST_READ,
      ST_WRITE: w_state_next = ST_ACK;
      ST_ACK:   w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_lane_en = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_lane_en[i] = i_wb_sel[i/8];
    end
  end

  assign w_wr_mask  = (r_state == ST_WRITE) && (i_wb_adr == ADR_MASK);
  assign w_wr_clear = (r_state == ST_WRITE) && (i_wb_adr == ADR_CLEAR);
  assign w_clr      = w_wr_clear ? (i_wb_dat[NUM_IRQ-1:0] & w_lane_en) : '0;
  assign w_active   = r_pend & ~r_mask;

`ifdef IRQ_CTRL_PRIO_ID_EN
  logic [31:0] w_active_32;
  logic [31:0] w_id;

  always_comb begin
    w_active_32                = '0;
    w_active_32[NUM_IRQ-1:0]   = w_active;
    w_id                       = '0;
    if (|w_active) begin
      w_id[31]  = 1'b1;
      w_id[4:0] = lowest_set(w_active_32);
    end
  end
`endif

  always_comb begin
    w_rd_data = '0;
    case (i_wb_adr)
      ADR_STATUS: w_rd_data[NUM_IRQ-1:0] = w_active;
      ADR_MASK:   w_rd_data[NUM_IRQ-1:0] = r_mask;
      ADR_RAW:    w_rd_data[NUM_IRQ-1:0] = w_sync;
`ifdef IRQ_CTRL_PRIO_ID_EN
      ADR_ID:     w_rd_data              = w_id;
`endif
      default:    w_rd_data              = '0;
    endcase
  end

  // NOTE: only control/status flops carry a reset; there is no storage array
  // here, so every register can safely be cleared asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend <= '0;
      r_mask <= MASK_RST[NUM_IRQ-1:0];
      r_irq  <= 1'b0;
      r_ack  <= 1'b0;
      r_rdat <= '0;
    end else begin
      // Set dominates clear so a source that is still asserted stays pending.
      r_pend <= (r_pend & ~w_clr) | w_sync;
      if (w_wr_mask) begin
        r_mask <= (r_mask & ~w_lane_en) | (i_wb_dat[NUM_IRQ-1:0] & w_lane_en);
      end
      r_irq <= |w_active;
      r_ack <= (r_state == ST_ACK);
      if (r_state == ST_READ) r_rdat <= w_rd_data;
    end
  end

  assign w_unused = ^{i_wb_dat, i_wb_sel};

  assign o_wb_dat = r_rdat;
  assign o_wb_ack = r_ack;
  assign o_irq    = r_irq;

endmodule
